// File: rtl/cdb_arbiter_if.sv
// Bundles the two completion push ports, their stalls, the CDB broadcast and the overflow flag.
interface cdb_arbiter_if #(
   parameter int ROB_W = 4
);
   logic             alu_valid;
   logic [ROB_W-1:0] alu_rob_id;
   logic [31:0]      alu_val;
   logic             alu_jmp;
   logic [31:0]      alu_addr;
   logic             alu_stall;

   logic             lsb_valid;
   logic [ROB_W-1:0] lsb_rob_id;
   logic [31:0]      lsb_val;
   logic             lsb_stall;

   logic             cdb_valid;
   logic [ROB_W-1:0] cdb_rob_id;
   logic [31:0]      cdb_val;
   logic             cdb_jmp;
   logic [31:0]      cdb_addr;
   logic             cdb_src;
   logic             ovf_err;

   modport master (
      output alu_valid, alu_rob_id, alu_val, alu_jmp, alu_addr,
      output lsb_valid, lsb_rob_id, lsb_val,
      input  alu_stall, lsb_stall,
      input  cdb_valid, cdb_rob_id, cdb_val, cdb_jmp, cdb_addr, cdb_src, ovf_err
   );

   modport slave (
      input  alu_valid, alu_rob_id, alu_val, alu_jmp, alu_addr,
      input  lsb_valid, lsb_rob_id, lsb_val,
      output alu_stall, lsb_stall,
      output cdb_valid, cdb_rob_id, cdb_val, cdb_jmp, cdb_addr, cdb_src, ovf_err
   );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin CDB arbiter over per-source ALU/LSB queues; one registered broadcast per cycle, push->broadcast one edge later.
// No downstream backpressure; producers throttle on *_stall (count >= DEPTH-1). CDB_BYPASS_EN lets an empty source's push win the same edge.
module cdb_arbiter #(
   parameter int ROB_W = 4,
   parameter int DEPTH = 4
) (
   input logic           clk_in,
   input logic           rst_in,
   input logic           rdy_in,
   input logic           rob_clear,
   cdb_arbiter_if.slave  bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   typedef struct packed {
      logic [ROB_W-1:0] rob_id;
      logic [31:0]      val;
      logic             jmp;
      logic [31:0]      addr;
   } ent_t;

   ent_t          mem [2][DEPTH];
   logic [PW-1:0] head [2];
   logic [PW-1:0] tail [2];
   logic [CW-1:0] cnt  [2];

   ent_t       in_ent [2];
   logic [1:0] in_vld;
   logic [1:0] nonempty, full, cand, pop, byp, push;
   logic       any, grant, last_grant;
   ent_t       sel;

   ent_t       cdb_q;
   logic       cdb_valid_q, cdb_src_q, ovf_q;

   always_comb begin
      in_ent[0] = '{rob_id: bus.alu_rob_id, val: bus.alu_val, jmp: bus.alu_jmp, addr: bus.alu_addr};
      in_ent[1] = '{rob_id: bus.lsb_rob_id, val: bus.lsb_val, jmp: 1'b0, addr: 32'd0};
      in_vld    = {bus.lsb_valid, bus.alu_valid};
      for (int s = 0; s < 2; s++) begin
         nonempty[s] = (cnt[s] != '0);
         full[s]     = (cnt[s] == CW'(DEPTH));
      end
`ifdef CDB_BYPASS_EN
      cand = nonempty | in_vld;
`else
      cand = nonempty;
`endif
      any   = |cand;
      // On a tie the source that did not win last time gets the bus.
      grant = (&cand) ? ~last_grant : cand[1];
      for (int s = 0; s < 2; s++) begin
         pop[s]  = any && (grant == 1'(s)) && nonempty[s];
         byp[s]  = any && (grant == 1'(s)) && !nonempty[s];
         push[s] = in_vld[s] && !full[s] && !byp[s];
      end
      sel = (pop[grant]) ? mem[grant][head[grant]] : in_ent[grant];
   end

   always_ff @(posedge clk_in) begin
      if (rst_in && rdy_in && !rob_clear) begin
         for (int s = 0; s < 2; s++)
            if (push[s]) mem[s][tail[s]] <= in_ent[s];
      end
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int s = 0; s < 2; s++) begin
            head[s] <= '0;
            tail[s] <= '0;
            cnt[s]  <= '0;
         end
         cdb_q       <= '0;
         cdb_valid_q <= 1'b0;
         cdb_src_q   <= 1'b0;
         last_grant  <= 1'b1;
         ovf_q       <= 1'b0;
      end else if (rdy_in) begin
         if (rob_clear) begin
            for (int s = 0; s < 2; s++) begin
               head[s] <= '0;
               tail[s] <= '0;
               cnt[s]  <= '0;
            end
            cdb_valid_q <= 1'b0;
            last_grant  <= 1'b1;
         end else begin
            for (int s = 0; s < 2; s++) begin
               if (push[s]) tail[s] <= tail[s] + 1'b1;
               if (pop[s])  head[s] <= head[s] + 1'b1;
               cnt[s] <= cnt[s] + CW'(push[s]) - CW'(pop[s]);
            end
            if (|(in_vld & full)) ovf_q <= 1'b1;
            cdb_valid_q <= any;
            if (any) begin
               cdb_q      <= sel;
               cdb_src_q  <= grant;
               last_grant <= grant;
            end
         end
      end
   end

   assign bus.alu_stall  = (cnt[0] >= CW'(DEPTH - 1));
   assign bus.lsb_stall  = (cnt[1] >= CW'(DEPTH - 1));
   assign bus.cdb_valid  = cdb_valid_q;
   assign bus.cdb_rob_id = cdb_q.rob_id;
   assign bus.cdb_val    = cdb_q.val;
   assign bus.cdb_jmp    = cdb_q.jmp;
   assign bus.cdb_addr   = cdb_q.addr;
   assign bus.cdb_src    = cdb_src_q;
   assign bus.ovf_err    = ovf_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: queue-level reference model predicts each broadcast and its cycle.
module tb_cdb_arbiter;
   localparam int ROB_W = 4;
   localparam int DEPTH = 4;

   logic clk = 1'b0, rst_n = 1'b0, rdy = 1'b1, clr = 1'b0;

   cdb_arbiter_if #(.ROB_W(ROB_W)) bus ();

   cdb_arbiter #(.ROB_W(ROB_W), .DEPTH(DEPTH)) dut (
      .clk_in   (clk),
      .rst_in   (rst_n),
      .rdy_in   (rdy),
      .rob_clear(clr),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int               cyc;
      logic [ROB_W-1:0] id;
      logic [31:0]      val;
      logic             jmp;
      logic [31:0]      addr;
      logic             src;
   } res_t;

   res_t qa[$], ql[$], exp_q[$];
   logic [ROB_W-1:0] obs_ids[$];
   int cyc = 0;
   bit edge_rdy = 1'b0;
   bit m_ovf = 1'b0;
   bit m_lg = 1'b1;
   int total = 0, bad = 0;

   function automatic void check(string n, logic [127:0] a, logic [127:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s act=%0h exp=%0h (cycle %0d)", n, a, e, cyc);
      end
   endfunction

   // Reference model: two FIFOs of results, arbitrated by queue occupancy.
   always @(posedge clk) begin
      res_t ia, il, win;
      int na, nl;
      bit ca, cl, g, used_a, used_l;
      cyc++;
      edge_rdy = rst_n && rdy;
      if (!rst_n) begin
         qa.delete(); ql.delete(); exp_q.delete();
         m_ovf = 1'b0; m_lg = 1'b1;
      end else if (rdy) begin
         if (clr) begin
            qa.delete(); ql.delete();
            m_lg = 1'b1;
         end else begin
            ia = '{cyc, bus.alu_rob_id, bus.alu_val, bus.alu_jmp, bus.alu_addr, 1'b0};
            il = '{cyc, bus.lsb_rob_id, bus.lsb_val, 1'b0, 32'd0, 1'b1};
            na = qa.size(); nl = ql.size();
            ca = (na > 0); cl = (nl > 0);
`ifdef CDB_BYPASS_EN
            ca = ca || bus.alu_valid;
            cl = cl || bus.lsb_valid;
`endif
            used_a = 1'b0; used_l = 1'b0;
            if (ca || cl) begin
               g = (ca && cl) ? !m_lg : cl;
               m_lg = g;
               if (!g) begin
                  if (na > 0) win = qa.pop_front();
                  else begin win = ia; used_a = 1'b1; end
               end else begin
                  if (nl > 0) win = ql.pop_front();
                  else begin win = il; used_l = 1'b1; end
               end
               win.cyc = cyc;
               exp_q.push_back(win);
            end
            if (bus.alu_valid && !used_a) begin
               if (na == DEPTH) m_ovf = 1'b1; else qa.push_back(ia);
            end
            if (bus.lsb_valid && !used_l) begin
               if (nl == DEPTH) m_ovf = 1'b1; else ql.push_back(il);
            end
         end
      end
   end

   // Monitor: compares the broadcast of the latest edge and the status outputs.
   always @(negedge clk) begin
      res_t e;
      if (rst_n) begin
         if (edge_rdy) begin
            if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
               e = exp_q.pop_front();
               check("cdb", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_val, bus.cdb_jmp, bus.cdb_addr, bus.cdb_src},
                            {1'b1, e.id, e.val, e.jmp, e.addr, e.src});
               if (bus.cdb_valid) obs_ids.push_back(bus.cdb_rob_id);
            end else begin
               check("cdb_idle", bus.cdb_valid, 1'b0);
            end
         end
         check("alu_stall", bus.alu_stall, (qa.size() >= DEPTH - 1));
         check("lsb_stall", bus.lsb_stall, (ql.size() >= DEPTH - 1));
         check("ovf_err", bus.ovf_err, m_ovf);
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic set_in(input bit av, input logic [3:0] aid, input logic [31:0] aval, input bit aj,
                         input logic [31:0] aad, input bit lv, input logic [3:0] lid, input logic [31:0] lval);
      bus.alu_valid = av; bus.alu_rob_id = aid; bus.alu_val = aval; bus.alu_jmp = aj; bus.alu_addr = aad;
      bus.lsb_valid = lv; bus.lsb_rob_id = lid; bus.lsb_val = lval;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         set_in(0, 0, 0, 0, 0, 0, 0, 0);
      end
   endtask

   task automatic reset_pulse();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_cdb", {bus.cdb_valid, bus.cdb_rob_id, bus.cdb_val, bus.cdb_jmp, bus.cdb_addr, bus.cdb_src}, '0);
      check("rst_flags", {bus.alu_stall, bus.lsb_stall, bus.ovf_err}, 3'b000);
      step();
      rst_n = 1'b1;
   endtask

   initial begin
      logic [ROB_W-1:0] want [6];
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      rdy = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("rst_cdb0", {bus.cdb_valid, bus.alu_stall, bus.lsb_stall, bus.ovf_err}, 4'b0000);
      rst_n = 1'b1;
      idle(10);

      // Single ALU result.
      step();
      set_in(1, 4'd3, 32'h1234, 1, 32'h100, 0, 0, 0);
      idle(5);

      // Both sources every cycle: strict alternation starting with the ALU.
      reset_pulse();
      obs_ids.delete();
      for (int i = 0; i < 3; i++) begin
         step();
         set_in(1, 4'(1 + i), 32'(100 + i), 0, 0, 1, 4'(9 + i), 32'(200 + i));
      end
      idle(10);
      want = '{4'd1, 4'd9, 4'd2, 4'd10, 4'd3, 4'd11};
      check("order_len", obs_ids.size(), 6);
      for (int i = 0; i < 6 && i < obs_ids.size(); i++) check("order_id", obs_ids[i], want[i]);

      // Overfill the LSB queue under ALU traffic.
      reset_pulse();
      for (int i = 0; i < 10; i++) begin
         step();
         set_in(!bus.alu_stall, 4'(i), 32'($urandom), 1'($urandom), 32'($urandom), 1, 4'(i + 5), 32'($urandom));
      end
      idle(12);
      check("ovf_set", bus.ovf_err, 1'b1);

      // Flush with two entries per queue and pushes in the flush cycle.
      reset_pulse();
      for (int i = 0; i < 3; i++) begin
         step();
         set_in(1, 4'(i + 1), 32'(i), 0, 0, 1, 4'(i + 8), 32'(i));
      end
      step();
      clr = 1'b1;
      set_in(1, 4'd14, 32'hdead, 1, 32'h4, 1, 4'd15, 32'hbeef);
      step();
      clr = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      check("clr_valid", {bus.cdb_valid, bus.alu_stall, bus.lsb_stall}, 3'b000);
      idle(6);

      // rdy low mid-stream, then an async reset mid-stream.
      for (int i = 0; i < 8; i++) begin
         step();
         rdy = !(i >= 3 && i < 6);
         set_in(1, 4'(i), 32'(i * 3), 1'(i), 32'(i * 7), 1, 4'(15 - i), 32'(i * 5));
      end
      step();
      rdy = 1'b1;
      set_in(1, 4'd2, 32'h55, 0, 0, 1, 4'd6, 32'h66);
      reset_pulse();
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      idle(4);

      // Randomized traffic with occasional stall violations, freezes and flushes.
      for (int i = 0; i < 500; i++) begin
         step();
         rdy = ($urandom_range(0, 9) != 0);
         clr = ($urandom_range(0, 39) == 0);
         set_in(($urandom_range(0, 2) != 0) && (!bus.alu_stall || $urandom_range(0, 7) == 0),
                4'($urandom), 32'($urandom), 1'($urandom), 32'($urandom),
                ($urandom_range(0, 2) != 0) && (!bus.lsb_stall || $urandom_range(0, 7) == 0),
                4'($urandom), 32'($urandom));
      end
      step();
      rdy = 1'b1;
      clr = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0);
      idle(12);
      check("drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
